// File: rtl/dn_seq_pkg.sv
// Shared types and defaults for the download-port sequencer.
package dn_seq_pkg;

   localparam int unsigned ADDR_W_DEF       = 16;
   localparam int unsigned DATA_W           = 8;
   localparam logic [15:0] BOOT_ROM_END_DEF = 16'd275;
   localparam logic [15:0] EXEC_ADDR_DEF    = 16'h0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      B_RD = 3'd1,
      B_WR = 3'd2,
      EXEC = 3'd3,
      HPS  = 3'd4
   } state_e;

endpackage

// File: rtl/dn_sequencer_if.sv
// Core download port: write channel plus execute strobe, driven by the sequencer.
interface dn_sequencer_if #(
   parameter int unsigned ADDR_W = 16
);
   import dn_seq_pkg::*;

   logic              dn_go;
   logic              dn_wr;
   logic [ADDR_W-1:0] dn_addr;
   logic [DATA_W-1:0] dn_data;
   logic              dn_ready;
   logic [ADDR_W-1:0] execute_addr;
   logic              execute_enable;

   modport master (
      output dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable,
      input  dn_ready
   );

   modport slave (
      input  dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable,
      output dn_ready
   );

endinterface

// File: rtl/dn_skid_buf.sv
// One-entry addr/data holding buffer between the HPS byte stream and the core port.
module dn_skid_buf
   import dn_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_drain,
   output logic              o_full,
   output logic              o_full_nxt_c,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              w_capture;
   logic              w_full_nxt;

   // A full buffer only empties; an empty one only fills.
   always_comb begin
      w_capture  = 1'b0;
      w_full_nxt = r_full;
      if (r_full) begin
         if (i_drain) w_full_nxt = 1'b0;
      end else if (i_wr) begin
         w_capture  = 1'b1;
         w_full_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_full <= w_full_nxt;
         if (w_capture) begin
            r_addr <= i_addr;
            r_data <= i_data;
         end
      end
   end

   assign o_full       = r_full;
   assign o_full_nxt_c = w_full_nxt;
   assign o_addr       = r_addr;
   assign o_data       = r_data;

   // The HPS side must honour the stall while an entry is held.
   a_no_wr_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(i_wr && r_full));

endmodule

// File: rtl/dn_sequencer.sv
// Arbitrates the core download port between the boot-ROM copier and HPS ioctl downloads.
module dn_sequencer
   import dn_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W       = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] BOOT_ROM_END = ADDR_W'(BOOT_ROM_END_DEF),
   parameter logic [ADDR_W-1:0] EXEC_ADDR    = ADDR_W'(EXEC_ADDR_DEF)
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              boot_start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              hps_download,
   input  logic              hps_wr,
   input  logic [ADDR_W-1:0] hps_addr,
   input  logic [DATA_W-1:0] hps_data,
   output logic              hps_wait,
   dn_sequencer_if.master    dn,
   output logic              boot_busy
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_dn_go;
   logic              r_dn_wr;
   logic [ADDR_W-1:0] r_dn_addr;
   logic [DATA_W-1:0] r_dn_data;
   logic              r_exec_en;
   logic [ADDR_W-1:0] r_exec_addr;
   logic              r_hps_wait;
   logic              r_boot_busy;

   state_e            w_state_nxt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              w_wr_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_exec_nxt;
   logic              w_drain;
   logic              w_full;
   logic              w_full_nxt;
   logic [ADDR_W-1:0] w_buf_addr;
   logic [DATA_W-1:0] w_buf_data;

   dn_skid_buf #(
      .ADDR_W (ADDR_W)
   ) u_skid (
      .clk          (clk_sys),
      .rst_n        (reset_n),
      .i_wr         (hps_wr),
      .i_addr       (hps_addr),
      .i_data       (hps_data),
      .i_drain      (w_drain),
      .o_full       (w_full),
      .o_full_nxt_c (w_full_nxt),
      .o_addr       (w_buf_addr),
      .o_data       (w_buf_data)
   );

   // Next-state and next-output decode; boot_start overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr_nxt    = 1'b0;
      w_addr_nxt  = r_dn_addr;
      w_data_nxt  = r_dn_data;
      w_exec_nxt  = 1'b0;
      w_drain     = 1'b0;

      case (r_state)
         IDLE: begin
            if (hps_download) w_state_nxt = HPS;
         end
         B_RD: begin
            w_state_nxt = B_WR;
         end
         B_WR: begin
            if (dn.dn_ready) begin
               w_wr_nxt   = 1'b1;
               w_addr_nxt = r_cnt;
               w_data_nxt = rom_data;
               if (r_cnt == BOOT_ROM_END) begin
                  w_state_nxt = EXEC;
               end else begin
                  w_cnt_nxt   = r_cnt + ADDR_W'(1);
                  w_state_nxt = B_RD;
               end
            end
         end
         EXEC: begin
            w_exec_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = hps_download ? HPS : IDLE;
         end
         HPS: begin
            if (w_full && dn.dn_ready) begin
               w_drain    = 1'b1;
               w_wr_nxt   = 1'b1;
               w_addr_nxt = w_buf_addr;
               w_data_nxt = w_buf_data;
            end
            if (!hps_download && !w_full) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (boot_start) begin
         w_state_nxt = B_RD;
         w_cnt_nxt   = '0;
         w_exec_nxt  = 1'b0;
      end
   end

   // State register; status outputs are registered from the next-state view so they align with it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_dn_go     <= 1'b0;
         r_dn_wr     <= 1'b0;
         r_dn_addr   <= '0;
         r_dn_data   <= '0;
         r_exec_en   <= 1'b0;
         r_exec_addr <= '0;
         r_hps_wait  <= 1'b0;
         r_boot_busy <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_dn_go     <= (w_state_nxt != IDLE);
         r_dn_wr     <= w_wr_nxt;
         r_dn_addr   <= w_addr_nxt;
         r_dn_data   <= w_data_nxt;
         r_exec_en   <= w_exec_nxt;
         if (w_exec_nxt) r_exec_addr <= EXEC_ADDR;
         r_hps_wait  <= w_full_nxt | (hps_download & (w_state_nxt != HPS));
         r_boot_busy <= (w_state_nxt == B_RD) || (w_state_nxt == B_WR) || (w_state_nxt == EXEC);
      end
   end

   assign rom_addr          = r_cnt;
   assign hps_wait          = r_hps_wait;
   assign boot_busy         = r_boot_busy;
   assign dn.dn_go          = r_dn_go;
   assign dn.dn_wr          = r_dn_wr;
   assign dn.dn_addr        = r_dn_addr;
   assign dn.dn_data        = r_dn_data;
   assign dn.execute_enable = r_exec_en;
   assign dn.execute_addr   = r_exec_addr;

endmodule

// File: tb/tb_dn_sequencer.sv
// Scoreboard bench for dn_sequencer: expected writes/executes queued by stimulus, checked by a monitor.
module tb_dn_sequencer;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct {
      logic go;
      int   gap;
   } exec_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        boot_start;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic        hps_download;
   logic        hps_wr;
   logic [15:0] hps_addr;
   logic [7:0]  hps_data;
   logic        hps_wait;
   logic        boot_busy;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int t_first = 0;
   logic        prev_wr   = 1'b0;
   logic [15:0] prev_addr = '0;

   wr_t   wr_q[$];
   exec_t ex_q[$];

   dn_sequencer_if #(.ADDR_W(16)) dn ();

   dn_sequencer dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .boot_start   (boot_start),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .hps_download (hps_download),
      .hps_wr       (hps_wr),
      .hps_addr     (hps_addr),
      .hps_data     (hps_data),
      .hps_wait     (hps_wait),
      .dn           (dn),
      .boot_busy    (boot_busy)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [7:0] rom_f(input logic [15:0] a);
      logic [15:0] t;
      t = a * 16'd37 + 16'd11;
      return t[7:0] ^ 8'(a >> 3);
   endfunction

   // Registered boot ROM model.
   always @(posedge clk_sys) rom_data <= rom_f(rom_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Monitor: every write and execute strobe is matched against the queues.
   always @(negedge clk_sys) begin
      wr_t   e;
      exec_t x;
      cyc++;
      if (reset_n) begin
         if (dn.dn_wr) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_wr", 32'(dn.dn_addr), 32'hFFFF_FFFF);
            end else begin
               e = wr_q.pop_front();
               chk("wr_addr", 32'(dn.dn_addr), 32'(e.a));
               chk("wr_data", 32'(dn.dn_data), 32'(e.d));
            end
            if (boot_busy && dn.dn_addr == 16'd0) t_first = cyc;
         end
         if (dn.execute_enable) begin
            if (ex_q.size() == 0) begin
               chk("unexpected_exec", 32'd1, 32'd0);
            end else begin
               x = ex_q.pop_front();
               chk("exec_addr", 32'(dn.execute_addr), 32'd0);
               chk("exec_dn_go", 32'(dn.dn_go), 32'(x.go));
               chk("exec_after_last_wr", {15'd0, prev_wr, prev_addr}, {15'd0, 1'b1, 16'd275});
               chk("exec_gap", 32'(cyc - t_first), 32'(x.gap));
            end
         end
      end
      prev_wr   = dn.dn_wr;
      prev_addr = dn.dn_addr;
   end

   task automatic push_boot(input int last);
      for (int i = 0; i <= last; i++) wr_q.push_back('{a: 16'(i), d: rom_f(16'(i))});
   endtask

   task automatic push_exec(input logic go, input int gap);
      ex_q.push_back('{go: go, gap: gap});
   endtask

   task automatic pulse_boot();
      @(negedge clk_sys);
      boot_start = 1'b1;
      @(negedge clk_sys);
      boot_start = 1'b0;
   endtask

   task automatic wait_wr(input logic [15:0] a, input int budget);
      bit found = 1'b0;
      for (int k = 0; k < budget && !found; k++) begin
         @(negedge clk_sys);
         if (dn.dn_wr && dn.dn_addr == a) found = 1'b1;
      end
      chk("wait_wr", 32'(found), 32'd1);
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget && (wr_q.size() != 0 || ex_q.size() != 0); k++) @(negedge clk_sys);
      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
      chk("exec_q_empty", 32'(ex_q.size()), 32'd0);
   endtask

   task automatic wait_idle(input int budget);
      bit idle = 1'b0;
      for (int k = 0; k < budget && !idle; k++) begin
         @(negedge clk_sys);
         if (!dn.dn_go) idle = 1'b1;
      end
      chk("return_idle", 32'(idle), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dn_go"}, 32'(dn.dn_go), 32'd0);
      chk({tag, "_dn_wr"}, 32'(dn.dn_wr), 32'd0);
      chk({tag, "_dn_addr"}, 32'(dn.dn_addr), 32'd0);
      chk({tag, "_dn_data"}, 32'(dn.dn_data), 32'd0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      chk({tag, "_exec_en"}, 32'(dn.execute_enable), 32'd0);
      chk({tag, "_exec_addr"}, 32'(dn.execute_addr), 32'd0);
      chk({tag, "_hps_wait"}, 32'(hps_wait), 32'd0);
      chk({tag, "_boot_busy"}, 32'(boot_busy), 32'd0);
   endtask

   initial begin
      int  bad;
      int  sent;
      bit  jw;
      bit  seen;

      reset_n      = 1'b0;
      boot_start   = 1'b0;
      hps_download = 1'b0;
      hps_wr       = 1'b0;
      hps_addr     = '0;
      hps_data     = '0;
      dn.dn_ready  = 1'b1;

      #12;
      chk_all_zero("reset");
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      // Plain boot copy
      push_boot(275);
      push_exec(1'b0, 551);
      pulse_boot();
      wait_drain(800);
      @(negedge clk_sys);
      chk("boot_done_dn_go", 32'(dn.dn_go), 32'd0);
      chk("boot_done_busy", 32'(boot_busy), 32'd0);

      // Backpressure at address 10
      push_boot(275);
      push_exec(1'b0, 555);
      pulse_boot();
      wait_wr(16'd9, 100);
      dn.dn_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_sys);
         chk("bp_no_wr", 32'(dn.dn_wr), 32'd0);
         chk("bp_rom_addr", 32'(rom_addr), 32'd10);
      end
      dn.dn_ready = 1'b1;
      wait_drain(800);

      // Restart at count 100
      push_boot(100);
      push_boot(275);
      push_exec(1'b0, 551);
      pulse_boot();
      wait_wr(16'd100, 400);
      boot_start = 1'b1;
      @(negedge clk_sys);
      boot_start = 1'b0;
      wait_drain(800);

      // HPS byte arriving during boot
      push_boot(275);
      wr_q.push_back('{a: 16'h0020, d: 8'hA5});
      push_exec(1'b1, 551);
      @(negedge clk_sys);
      hps_download = 1'b1;
      boot_start   = 1'b1;
      @(negedge clk_sys);
      boot_start   = 1'b0;
      wait_wr(16'd49, 200);
      hps_addr = 16'h0020;
      hps_data = 8'hA5;
      hps_wr   = 1'b1;
      @(negedge clk_sys);
      hps_wr = 1'b0;
      bad  = 0;
      seen = 1'b0;
      for (int k = 0; k < 800 && !seen; k++) begin
         if (dn.execute_enable) seen = 1'b1;
         if (!hps_wait) bad++;
         if (!seen) @(negedge clk_sys);
      end
      chk("hps_wait_during_boot", 32'(bad), 32'd0);
      chk("exec_seen_hps", 32'(seen), 32'd1);
      @(negedge clk_sys);
      chk("hps_wait_after_drain", 32'(hps_wait), 32'd0);
      hps_download = 1'b0;
      wait_idle(20);
      wait_drain(20);

      // HPS stream alone with dn_ready toggling
      for (int i = 0; i < 8; i++) wr_q.push_back('{a: 16'h0100 + 16'(i), d: 8'hC0 + 8'(i)});
      @(negedge clk_sys);
      hps_download = 1'b1;
      sent = 0;
      jw   = 1'b0;
      for (int k = 0; k < 200 && (sent < 8 || jw); k++) begin
         @(negedge clk_sys);
         if (jw) chk("hps_wait_full", 32'(hps_wait), 32'd1);
         jw          = 1'b0;
         hps_wr      = 1'b0;
         dn.dn_ready = ~dn.dn_ready;
         if (!hps_wait && sent < 8) begin
            hps_addr = 16'h0100 + 16'(sent);
            hps_data = 8'hC0 + 8'(sent);
            hps_wr   = 1'b1;
            sent++;
            jw = 1'b1;
         end
      end
      chk("hps_sent", 32'(sent), 32'd8);
      hps_wr       = 1'b0;
      dn.dn_ready  = 1'b1;
      hps_download = 1'b0;
      wait_idle(40);
      wait_drain(20);

      // Asynchronous reset while stalled in B_WR
      push_boot(4);
      pulse_boot();
      wait_wr(16'd4, 100);
      dn.dn_ready = 1'b0;
      repeat (2) @(negedge clk_sys);
      #3 reset_n = 1'b0;
      #1 chk_all_zero("async_rst");
      @(negedge clk_sys);
      reset_n     = 1'b1;
      dn.dn_ready = 1'b1;
      repeat (600) @(negedge clk_sys);
      chk("post_rst_dn_go", 32'(dn.dn_go), 32'd0);
      wait_drain(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
